// File: rtl/dma_elem_unpack.sv
// Wide-to-narrow read-data unpacker: holds one host buffer word and emits its valid
// elements in ascending address order, optionally byte-reversing each element.
module dma_elem_unpack #(
    parameter  int WORD_BYTES = 16,
    parameter  int ELEM_BYTES = 4,
    localparam int N          = WORD_BYTES / ELEM_BYTES,
    localparam int CW         = $clog2(N) + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [0:8*WORD_BYTES-1]   in_data,
    input  logic [CW-1:0]             in_nelem,
    input  logic                      in_last,
    input  logic                      in_little_endian,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [0:8*ELEM_BYTES-1]   out_data,
    output logic                      out_last
);

    localparam int EW = 8 * ELEM_BYTES;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                    state_reg, state_next;
    logic [CW-1:0]             idx_reg, idx_next;
    logic [CW-1:0]             nelem_reg;
    logic [0:8*WORD_BYTES-1]   word_reg;
    logic                      last_reg;
    logic                      le_reg;
    logic                      load;

    logic                      busy;
    logic                      final_elem;
    logic [CW-1:0]             nelem_clamped;
    logic [0:EW-1]             elems [N];
    logic [0:EW-1]             elem_sel;
    logic [0:EW-1]             elem_rev;

    assign busy       = (state_reg == DRAIN);
    assign final_elem = (idx_reg == nelem_reg - CW'(1));

    // A zero or oversized count means the whole word is valid.
    assign nelem_clamped = ((in_nelem == '0) || (in_nelem > CW'(N))) ? CW'(N) : in_nelem;

    // in_ready never depends on in_valid, so the upstream FIFO sees no combinational loop.
    assign in_ready  = !reset && (!busy || (final_elem && out_ready));
    assign out_valid = busy;
    assign out_last  = busy && last_reg && final_elem;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elem
            assign elems[gi] = word_reg[EW*gi +: EW];
        end
        for (genvar gi = 0; gi < ELEM_BYTES; gi++) begin : g_rev
            assign elem_rev[8*gi +: 8] = elem_sel[8*(ELEM_BYTES-1-gi) +: 8];
        end
    endgenerate

    always_comb begin
        elem_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_reg == CW'(i)) begin
                elem_sel = elems[i];
            end
        end
    end

    assign out_data = !busy ? '0 : (le_reg ? elem_rev : elem_sel);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        load       = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (in_valid) begin
                    load       = 1'b1;
                    idx_next   = '0;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (final_elem) begin
                        // Refill in the final-element cycle so consecutive words leave no bubble.
                        if (in_valid) begin
                            load     = 1'b1;
                            idx_next = '0;
                        end else begin
                            state_next = EMPTY;
                        end
                    end else begin
                        idx_next = idx_reg + CW'(1);
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
            idx_reg   <= '0;
            nelem_reg <= CW'(N);
            word_reg  <= '0;
            last_reg  <= 1'b0;
            le_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (load) begin
                word_reg  <= in_data;
                nelem_reg <= nelem_clamped;
                last_reg  <= in_last;
                le_reg    <= in_little_endian;
            end
        end
    end

endmodule

// File: tb/tb_dma_elem_unpack.sv
// Directed bench for dma_elem_unpack (16-byte words, 4-byte elements) with hand-computed
// expected elements, backpressure patterns and reset-during-drain.
module tb_dma_elem_unpack;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [0:127]   in_data;
    logic [2:0]     in_nelem;
    logic           in_last;
    logic           in_little_endian;
    logic           out_valid;
    logic           out_ready;
    logic [0:31]    out_data;
    logic           out_last;

    int errors = 0;
    int checks = 0;

    // Word table for a run and the hand-computed element sequence it must produce.
    logic [127:0] wd [8];
    logic [2:0]   wn [8];
    bit           wl [8];
    bit           we [8];
    logic [31:0]  ed [16];
    bit           el [16];   // out_last expected
    bit           ef [16];   // final element of its word

    dma_elem_unpack #(.WORD_BYTES(16), .ELEM_BYTES(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_nelem         (in_nelem),
        .in_last          (in_last),
        .in_little_endian (in_little_endian),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string name, input int nw, input int ne, input bit [3:0] pat);
        int          wi = 0;
        int          ei = 0;
        int          cyc = 0;
        int          first = -1;
        int          bubbles = 0;
        bit          prev_stall = 1'b0;
        logic [31:0] pd = '0;
        logic        pl = 1'b0;
        bit          exp_rdy;
        while (ei < ne && cyc < 200) begin
            out_ready = pat[cyc % 4];
            if (wi < nw) begin
                in_valid         = 1'b1;
                in_data          = wd[wi];
                in_nelem         = wn[wi];
                in_last          = wl[wi];
                in_little_endian = we[wi];
            end else begin
                in_valid         = 1'b0;
                in_data          = {$urandom, $urandom, $urandom, $urandom};
                in_nelem         = 3'($urandom);
                in_last          = 1'($urandom);
                in_little_endian = 1'($urandom);
            end
            #1;
            if (prev_stall) begin
                chk({name, ":hold_valid"}, out_valid, 1'b1);
                chk({name, ":hold_data"}, out_data, pd);
                chk({name, ":hold_last"}, out_last, pl);
            end
            if (out_valid) begin
                if (first < 0) first = cyc;
                exp_rdy = ef[ei] && out_ready;
            end else begin
                exp_rdy = 1'b1;
                if (first >= 0) bubbles++;
            end
            chk({name, ":in_ready"}, in_ready, exp_rdy);
            if (out_valid && out_ready) begin
                $display("%s cycle %0d elem %0d data=%h last=%b", name, cyc, ei, out_data, out_last);
                chk({name, ":data"}, out_data, ed[ei]);
                chk({name, ":last"}, out_last, el[ei]);
                ei++;
            end
            if (in_valid && in_ready) wi++;
            prev_stall = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({name, ":elem_count"}, ei, ne);
        chk({name, ":words_taken"}, wi, nw);
        chk({name, ":first_latency"}, first, 1);
        if (pat == 4'b1111) chk({name, ":bubbles"}, bubbles, 0);
        #1;
        chk({name, ":idle_after"}, out_valid, 1'b0);
        @(negedge clk);
    endtask

    task automatic set_elems(input int base, input logic [31:0] a, b, c, d, input bit lst);
        ed[base] = a; ed[base+1] = b; ed[base+2] = c; ed[base+3] = d;
        for (int i = 0; i < 4; i++) begin
            ef[base+i] = (i == 3);
            el[base+i] = (i == 3) && lst;
        end
    endtask

    localparam logic [127:0] W_A = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] W_B = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [127:0] W_C = 128'h202122232425262728292A2B2C2D2E2F;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_nelem = '0;
        in_last = 1'b0; in_little_endian = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst:in_ready", in_ready, 1'b0);
        chk("rst:out_valid", out_valid, 1'b0);
        chk("rst:out_last", out_last, 1'b0);
        chk("rst:out_data", out_data, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst:in_ready_after", in_ready, 1'b1);
        @(negedge clk);

        // Big-endian full word
        wd[0] = W_A; wn[0] = 3'd4; wl[0] = 1'b0; we[0] = 1'b0;
        set_elems(0, 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 1'b0);
        run("be_full", 1, 4, 4'b1111);

        // Little-endian full word, last
        wd[0] = W_A; wn[0] = 3'd4; wl[0] = 1'b1; we[0] = 1'b1;
        set_elems(0, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 1'b1);
        run("le_full", 1, 4, 4'b1111);

        // Partial word: only two elements, out_last on the second
        wd[0] = W_A; wn[0] = 3'd2; wl[0] = 1'b1; we[0] = 1'b0;
        ed[0] = 32'h00010203; ef[0] = 1'b0; el[0] = 1'b0;
        ed[1] = 32'h04050607; ef[1] = 1'b1; el[1] = 1'b1;
        run("partial", 1, 2, 4'b1111);

        // Clamp: nelem=0 and nelem=7 both mean four elements, back to back
        wd[0] = W_B; wn[0] = 3'd0; wl[0] = 1'b0; we[0] = 1'b1;
        wd[1] = W_A; wn[1] = 3'd7; wl[1] = 1'b1; we[1] = 1'b0;
        set_elems(0, 32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C, 1'b0);
        set_elems(4, 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 1'b1);
        run("clamp", 2, 8, 4'b1111);

        // Back-to-back full words, no gap
        wd[0] = W_A; wn[0] = 3'd4; wl[0] = 1'b0; we[0] = 1'b0;
        wd[1] = W_B; wn[1] = 3'd4; wl[1] = 1'b1; we[1] = 1'b0;
        set_elems(0, 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 1'b0);
        set_elems(4, 32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F, 1'b1);
        run("b2b", 2, 8, 4'b1111);

        // Backpressure 1,0,0,1 over three words
        wd[0] = W_A; wn[0] = 3'd4; wl[0] = 1'b0; we[0] = 1'b0;
        wd[1] = W_A; wn[1] = 3'd4; wl[1] = 1'b0; we[1] = 1'b1;
        wd[2] = W_B; wn[2] = 3'd4; wl[2] = 1'b1; we[2] = 1'b0;
        set_elems(0, 32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 1'b0);
        set_elems(4, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 1'b0);
        set_elems(8, 32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F, 1'b1);
        run("bp", 3, 12, 4'b1001);

        // Reset after two of four elements have been taken
        out_ready = 1'b1; in_valid = 1'b1; in_data = W_A; in_nelem = 3'd4;
        in_last = 1'b1; in_little_endian = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rstd:elem0", out_data, 32'h00010203);
        @(negedge clk);
        #1;
        chk("rstd:elem1", out_data, 32'h04050607);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstd:in_ready_in_reset", in_ready, 1'b0);
        @(negedge clk);
        #1;
        chk("rstd:out_valid", out_valid, 1'b0);
        chk("rstd:out_last", out_last, 1'b0);
        chk("rstd:out_data", out_data, 32'h0);
        chk("rstd:in_ready", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("rstd:in_ready_after", in_ready, 1'b1);
        @(negedge clk);

        wd[0] = W_C; wn[0] = 3'd3; wl[0] = 1'b1; we[0] = 1'b0;
        ed[0] = 32'h20212223; ef[0] = 1'b0; el[0] = 1'b0;
        ed[1] = 32'h24252627; ef[1] = 1'b0; el[1] = 1'b0;
        ed[2] = 32'h28292A2B; ef[2] = 1'b1; el[2] = 1'b1;
        run("post_rst", 1, 3, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
